kernel_clk_freq_meter: RTL and testbench
========================================

// Module: kernel_clk_freq_meter
// PURPOSE
//  Measures the kernel clock from the clk_50 domain. Input is the divided kernel-clock tap
//  (MSB of the kernel-clock LED divider; toggles at f_kernel / 2^DIV_LOG2).
//  Counts tap rising edges over a fixed gate window of fpga_clk_50 cycles.
//  Publishes one result per window for the HPS status path and for the bring-up LEDs.
//  f_kernel = meas_count * 2^DIV_LOG2 * 50e6 / GATE_CYCLES; software does the scaling.
// PARAMETERS
//  GATE_CYCLES  50_000_000  gate window length in fpga_clk_50 cycles; legal range 2..2^32-1
//  COUNT_W      32          width of the edge counter and meas_count
//  SYNC_STAGES  3           synchronizer flops on clk_tap_async; minimum 2
//  DIV_LOG2     27          tap divide ratio (log2); informational only, used by TB and software
// PORTS
//  fpga_clk_50    in   1        50 MHz reference; the only clock
//  fpga_reset_n   in   1        reset, asynchronous assert, active-low
//  meter_en       in   1        1 = measure continuously; 0 = abort and idle
//  clk_tap_async  in   1        divided kernel clock, asynchronous to fpga_clk_50
//  meas_count     out  COUNT_W  rising edges counted in the last completed window
//  meas_valid     out  1        single-cycle pulse; meas_count updated this cycle
//  meas_overflow  out  1        last window saturated at 2^COUNT_W-1
//  meas_stuck     out  1        last window saw zero edges
//  window_active  out  1        1 while in GATE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0, synchronizer flops 0.
//  Synchronizer: SYNC_STAGES flops.
//   - rise = sync_out & ~sync_d, where sync_d is one extra flop.
//   - Latency: an edge on the pin is counted SYNC_STAGES+1 cycles later.
//  FSM states: IDLE, ARM, GATE.
//   - IDLE: leave when meter_en=1 -> ARM.
//   - ARM: wait exactly SYNC_STAGES+1 cycles to flush stale samples; rises are ignored.
//     Then -> GATE with gate_cnt=0 and edge_cnt=0.
//   - GATE: gate_cnt counts 0..GATE_CYCLES-1.
//     - Each cycle with rise: edge_cnt increments, saturating at 2^COUNT_W-1.
//     - Terminal cycle (gate_cnt==GATE_CYCLES-1): the rise in that cycle belongs to the closing window.
//     - On the clock edge ending the terminal cycle, register:
//       meas_count    <= sat(edge_cnt + rise)
//       meas_overflow <= saturation hit
//       meas_stuck    <= (result==0)
//       meas_valid    <= 1 for one cycle
//     - In that same cycle edge_cnt <= 0 and gate_cnt <= 0, so the next window starts with no dead cycle.
//     - meas_valid pulses are therefore exactly GATE_CYCLES apart.
//  meter_en=0 in any state:
//   - Next state is IDLE; the partial window is discarded; no meas_valid.
//   - meas_count, meas_overflow and meas_stuck hold their last values.
//   - If meter_en falls in the terminal GATE cycle, the result is discarded.
//  meter_en re-asserted: always goes through ARM again.
//  Reset asserted mid-window: asynchronous clear to the reset values; no pulse on release.
//  Saturation: the counter never wraps; once saturated, meas_overflow=1 for that window.
//  gate_cnt width: $clog2(GATE_CYCLES).
// STRUCTURE
//  Package kclk_meter_pkg:
//   - FSM state enum (IDLE/ARM/GATE)
//   - default GATE_CYCLES
//   - clk_50 frequency constant
//   - DIV_LOG2 shared with the LED divider
//  Sub-module sync_bit #(STAGES): multi-flop synchronizer with async active-low reset.
//   - Reused for other asynchronous status inputs.
//  Top: FSM, gate counter, saturating edge counter, result registers.
// TESTING (GATE_CYCLES=100, SYNC_STAGES=3 unless noted)
//  1. Tap rises every 10 clk_50 cycles, meter_en=1.
//     -> every window after the first gives meas_count=10, overflow=0, stuck=0.
//     -> meas_valid pulses are 100 cycles apart.
//  2. Tap held at 0, then held at 1.
//     -> meas_count=0 and meas_stuck=1 each window.
//  3. COUNT_W=3, tap rises every 4 cycles (25 edges per window).
//     -> meas_count=7, meas_overflow=1.
//  4. Drop meter_en at gate_cnt=50.
//     -> no meas_valid; outputs hold their previous values; window_active=0 next cycle.
//     -> Re-assert: the first valid appears 4+100 cycles later.
//  5. Assert fpga_reset_n=0 at gate_cnt=60.
//     -> all outputs 0 at once; no meas_valid after release until meter_en restarts ARM.
//  6. Tap edge placed in the terminal gate cycle (after sync latency).
//     -> counted in the closing window, not the next.
//     -> The sum over consecutive windows equals the total number of edges driven.

Source files
------------

// File: rtl/kernel_clk_freq_meter_pkg.sv
// Shared types and constants for the kernel-clock frequency meter and the
// LED divider that produces its tap.
package kclk_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_GATE = 2'd2
    } kclk_state_e;

    localparam int unsigned CLK_50_HZ           = 32'd50_000_000;
    localparam int unsigned GATE_CYCLES_DEFAULT = 32'd50_000_000;
    localparam int unsigned COUNT_W_DEFAULT     = 32;
    localparam int unsigned SYNC_STAGES_DEFAULT = 3;
    localparam int unsigned DIV_LOG2            = 27;

    // Kernel clock in Hz for a published count; exact while the product fits 64 bits.
    function automatic longint unsigned kernel_hz(input longint unsigned count,
                                                  input longint unsigned gate_cycles);
        return ((count << DIV_LOG2) * CLK_50_HZ) / gate_cycles;
    endfunction

endpackage

// File: rtl/kernel_clk_freq_meter_if.sv
// Control and result bundle between the meter and its consumers (HPS status, LEDs).
interface kernel_clk_freq_meter_if
    import kclk_meter_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEFAULT
);
    logic               meter_en;
    logic               clk_tap_async;
    logic [COUNT_W-1:0] meas_count;
    logic               meas_valid;
    logic               meas_overflow;
    logic               meas_stuck;
    logic               window_active;
    kclk_state_e        dbg_state;

    // meas_valid is a one-cycle strobe with no ready: the consumer must capture
    // meas_count/overflow/stuck in that cycle; they then hold until the next strobe.
    modport master (
        output meter_en, clk_tap_async,
        input  meas_count, meas_valid, meas_overflow, meas_stuck, window_active, dbg_state
    );

    modport slave (
        input  meter_en, clk_tap_async,
        output meas_count, meas_valid, meas_overflow, meas_stuck, window_active, dbg_state
    );

endinterface

// File: rtl/kernel_clk_freq_meter_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level; async active-low reset.
module sync_bit #(
    parameter int unsigned STAGES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/kernel_clk_freq_meter.sv
// Kernel-clock frequency meter: counts synchronized rising edges of the divided
// kernel-clock tap over back-to-back windows of GATE_CYCLES fpga_clk_50 cycles.
module kernel_clk_freq_meter
    import kclk_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEFAULT,
    parameter int unsigned COUNT_W     = COUNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                   fpga_clk_50,
    input  logic                   fpga_reset_n,
    kernel_clk_freq_meter_if.slave meter
);
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam int unsigned ARM_W  = $clog2(SYNC_STAGES + 1);

    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(SYNC_STAGES);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    kclk_state_e        r_state;
    kclk_state_e        w_next_state;
    logic [ARM_W-1:0]   r_arm_cnt;
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [COUNT_W-1:0] r_edge_cnt;
    logic [COUNT_W-1:0] w_edge_next;
    logic               r_ovf_seen;
    logic               w_ovf_next;
    logic               w_sync_out;
    logic               r_sync_d;
    logic               w_rise;
    logic               w_in_gate;
    logic               w_arm_done;
    logic               w_terminal;
    logic               w_close;
    logic [COUNT_W-1:0] r_meas_count;
    logic               r_meas_valid;
    logic               r_meas_ovf;
    logic               r_meas_stuck;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_tap_sync (
        .i_clk   (fpga_clk_50),
        .i_rst_n (fpga_reset_n),
        .i_d     (meter.clk_tap_async),
        .o_q     (w_sync_out)
    );

    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= w_sync_out;
        end
    end

    assign w_rise = w_sync_out & ~r_sync_d;

    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Dropping meter_en wins over every transition, including the terminal GATE cycle.
    always_comb begin
        w_next_state = r_state;
        if (!meter.meter_en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_ARM;
                ST_ARM:  w_next_state = w_arm_done ? ST_GATE : ST_ARM;
                ST_GATE: w_next_state = ST_GATE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_in_gate  = (r_state == ST_GATE);
        w_arm_done = (r_state == ST_ARM) && (r_arm_cnt == ARM_LAST);
        w_terminal = w_in_gate && (r_gate_cnt == GATE_LAST);
        w_close    = w_terminal && meter.meter_en;
    end

    // Includes the current cycle's rise so the terminal cycle's edge closes with its window.
    always_comb begin
        w_edge_next = r_edge_cnt;
        w_ovf_next  = r_ovf_seen;
        if (w_rise) begin
            if (r_edge_cnt == CNT_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_edge_next = r_edge_cnt + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            r_arm_cnt  <= '0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf_seen <= 1'b0;
        end else begin
            if ((r_state == ST_ARM) && !w_arm_done && meter.meter_en) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end else begin
                r_arm_cnt <= '0;
            end

            // Outside an active window, and at its terminal cycle, the counters restart at zero.
            if (w_in_gate && meter.meter_en && !w_terminal) begin
                r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                r_edge_cnt <= w_edge_next;
                r_ovf_seen <= w_ovf_next;
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_ovf_seen <= 1'b0;
            end
        end
    end

    always_ff @(posedge fpga_clk_50 or negedge fpga_reset_n) begin
        if (!fpga_reset_n) begin
            r_meas_count <= '0;
            r_meas_valid <= 1'b0;
            r_meas_ovf   <= 1'b0;
            r_meas_stuck <= 1'b0;
        end else begin
            r_meas_valid <= w_close;
            if (w_close) begin
                r_meas_count <= w_edge_next;
                r_meas_ovf   <= w_ovf_next;
                r_meas_stuck <= (w_edge_next == '0);
            end
        end
    end

    assign meter.meas_count    = r_meas_count;
    assign meter.meas_valid    = r_meas_valid;
    assign meter.meas_overflow = r_meas_ovf;
    assign meter.meas_stuck    = r_meas_stuck;
    assign meter.window_active = w_in_gate;
    assign meter.dbg_state     = r_state;

endmodule

// File: tb/tb_kernel_clk_freq_meter.sv
// Directed bench for kernel_clk_freq_meter: a 32-bit meter plus a 3-bit meter
// for saturation, both with a 100-cycle window and 3 synchronizer stages.
module tb_kernel_clk_freq_meter;
    import kclk_meter_pkg::*;

    localparam int GATE = 100;
    localparam int SYNC = 3;
    // meter_en is sampled one edge after it is driven, then ARM, then the window.
    localparam int FIRST_VALID = 1 + (SYNC + 1) + GATE;

    logic fpga_clk_50 = 1'b0;
    logic fpga_reset_n = 1'b0;

    always #10 fpga_clk_50 = ~fpga_clk_50;

    kernel_clk_freq_meter_if #(.COUNT_W(32)) mif ();
    kernel_clk_freq_meter_if #(.COUNT_W(3))  sif ();

    kernel_clk_freq_meter #(
        .GATE_CYCLES (GATE),
        .COUNT_W     (32),
        .SYNC_STAGES (SYNC)
    ) dut (
        .fpga_clk_50  (fpga_clk_50),
        .fpga_reset_n (fpga_reset_n),
        .meter        (mif.slave)
    );

    kernel_clk_freq_meter #(
        .GATE_CYCLES (GATE),
        .COUNT_W     (3),
        .SYNC_STAGES (SYNC)
    ) dut_sat (
        .fpga_clk_50  (fpga_clk_50),
        .fpga_reset_n (fpga_reset_n),
        .meter        (sif.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tap_period = 0;
    int sat_period = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clocks; inputs change and outputs are read 1 ns after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fpga_clk_50);
            #1;
            cyc++;
            if (tap_period != 0) mif.clk_tap_async = ((cyc % tap_period) < (tap_period / 2));
            if (sat_period != 0) sif.clk_tap_async = ((cyc % sat_period) < (sat_period / 2));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget, output int waited);
        waited = 0;
        do begin
            step(1);
            waited++;
        end while (!mif.meas_valid && waited < budget);
        check({tag, "_valid"}, 32'(mif.meas_valid), 32'd1);
    endtask

    task automatic check_result(input string tag, input int cnt, input bit ovf, input bit stuck);
        check({tag, "_count"}, mif.meas_count, 32'(cnt));
        check({tag, "_ovf"}, 32'(mif.meas_overflow), 32'(ovf));
        check({tag, "_stuck"}, 32'(mif.meas_stuck), 32'(stuck));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int prev_cyc;
        int seen;
        int c1, c2, c3;

        mif.meter_en = 1'b0;
        mif.clk_tap_async = 1'b0;
        sif.meter_en = 1'b0;
        sif.clk_tap_async = 1'b0;

        // Reset state
        step(3);
        check("rst_count", mif.meas_count, 32'd0);
        check("rst_valid", 32'(mif.meas_valid), 32'd0);
        check("rst_ovf", 32'(mif.meas_overflow), 32'd0);
        check("rst_stuck", 32'(mif.meas_stuck), 32'd0);
        check("rst_active", 32'(mif.window_active), 32'd0);
        check("rst_state", 32'(mif.dbg_state), 32'(ST_IDLE));
        fpga_reset_n = 1'b1;
        step(3);
        check("idle_disabled_state", 32'(mif.dbg_state), 32'(ST_IDLE));

        // Periodic taps: every 10 cycles on the main meter, every 4 on the 3-bit meter
        tap_period = 10;
        sat_period = 4;
        mif.meter_en = 1'b1;
        sif.meter_en = 1'b1;
        wait_valid("t1_first", 300, w);
        check("t1_first_latency", 32'(w), 32'(FIRST_VALID));
        check("t3_sat_valid", 32'(sif.meas_valid), 32'd1);
        check("t3_sat_count", 32'(sif.meas_count), 32'd7);
        check("t3_sat_ovf", 32'(sif.meas_overflow), 32'd1);
        check("t3_sat_stuck", 32'(sif.meas_stuck), 32'd0);
        sif.meter_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            prev_cyc = cyc;
            wait_valid("t1_win", 200, w);
            check_result("t1_win", 10, 1'b0, 1'b0);
            check("t1_spacing", 32'(cyc - prev_cyc), 32'(GATE));
        end
        check("t1_active", 32'(mif.window_active), 32'd1);

        // Abort at gate_cnt=50: no result, outputs hold, restart goes through ARM
        step(50);
        mif.meter_en = 1'b0;
        step(1);
        check("t4_active_off", 32'(mif.window_active), 32'd0);
        check("t4_state", 32'(mif.dbg_state), 32'(ST_IDLE));
        seen = 0;
        for (int i = 0; i < 150; i++) begin
            step(1);
            if (mif.meas_valid) seen++;
        end
        check("t4_no_valid", 32'(seen), 32'd0);
        check_result("t4_hold", 10, 1'b0, 1'b0);
        mif.meter_en = 1'b1;
        wait_valid("t4_restart", 300, w);
        check("t4_restart_latency", 32'(w), 32'(FIRST_VALID));
        check_result("t4_restart", 10, 1'b0, 1'b0);

        // Reset at gate_cnt=60: immediate clear, no pulse until a fresh ARM+window
        step(60);
        fpga_reset_n = 1'b0;
        #1;
        check("t5_count", mif.meas_count, 32'd0);
        check("t5_valid", 32'(mif.meas_valid), 32'd0);
        check("t5_ovf", 32'(mif.meas_overflow), 32'd0);
        check("t5_stuck", 32'(mif.meas_stuck), 32'd0);
        check("t5_active", 32'(mif.window_active), 32'd0);
        step(3);
        fpga_reset_n = 1'b1;
        wait_valid("t5_after", 300, w);
        check("t5_after_latency", 32'(w), 32'(FIRST_VALID));
        check_result("t5_after", 10, 1'b0, 1'b0);

        // Tap held low, then one rise and held high
        tap_period = 0;
        mif.clk_tap_async = 1'b0;
        wait_valid("t2_flush", 200, w);
        wait_valid("t2_low", 200, w);
        check_result("t2_low", 0, 1'b0, 1'b1);
        mif.clk_tap_async = 1'b1;
        wait_valid("t2_rise", 200, w);
        check_result("t2_rise", 1, 1'b0, 1'b0);
        wait_valid("t2_high", 200, w);
        check_result("t2_high", 0, 1'b0, 1'b1);

        // Edge landing in the terminal cycle, then one in gate_cnt=1 of the next window
        mif.clk_tap_async = 1'b0;
        wait_valid("t6_quiet", 200, w);
        check_result("t6_quiet", 0, 1'b0, 1'b1);
        step(96);
        mif.clk_tap_async = 1'b1;
        step(1);
        mif.clk_tap_async = 1'b0;
        step(1);
        mif.clk_tap_async = 1'b1;
        step(1);
        mif.clk_tap_async = 1'b0;
        wait_valid("t6_close", 10, w);
        check("t6_close_latency", 32'(w), 32'd1);
        check_result("t6_close", 1, 1'b0, 1'b0);
        c1 = int'(mif.meas_count);
        prev_cyc = cyc;
        wait_valid("t6_next", 200, w);
        check("t6_next_spacing", 32'(cyc - prev_cyc), 32'(GATE));
        check_result("t6_next", 1, 1'b0, 1'b0);
        c2 = int'(mif.meas_count);
        wait_valid("t6_after", 200, w);
        check_result("t6_after", 0, 1'b0, 1'b1);
        c3 = int'(mif.meas_count);
        check("t6_sum", 32'(c1 + c2 + c3), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
